// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and byte-enable helper for the load/store unit
//
// Purpose: RV32I load/store funct3 encodings, the LSU FSM state type and
//          the byte-enable computation shared by the datapath.
// Contents:
//   LB, LH, LW, LBU, LHU, SB, SH, SW : funct3 encodings
//   lsu_state_e                      : IDLE, REQ, WAIT, RESP
//   byte_en(funct3, offset)          : 4-bit lane mask for an access
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Access size lives in funct3[1:0] for both loads and stores.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << {offset[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane placement and load extraction/extension
//
// Purpose: turns an LSB-aligned store operand into lane-replicated write
//          data plus byte enables, and pulls the addressed lane out of a
//          returned memory word with sign or zero extension.
// Ports:
//   funct3     in  3    : access type (load or store encoding)
//   offset     in  2    : byte offset within the word (already force-aligned)
//   wdata      in  XLEN : store data, LSB-aligned
//   rdata      in  XLEN : whole word returned by memory
//   be         out 4    : byte enables
//   wdata_lane out XLEN : replicated store data
//   rdata_ext  out XLEN : extracted and extended load data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [XLEN-1:0] shifted;

  assign be      = byte_en(funct3, offset);
  assign shifted = rdata >> {offset, 3'b000};

  // Replicating the operand into every lane lets memory pick it up with
  // the byte enables alone, no shifter needed on the write path.
  always_comb begin
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00:   wdata_lane = {(XLEN/8){wdata[7:0]}};
      2'b01:   wdata_lane = {(XLEN/16){wdata[15:0]}};
      default: wdata_lane = wdata;
    endcase
  end

  always_comb begin
    rdata_ext = rdata;
    case (funct3)
      LB:      rdata_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:      rdata_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LBU:     rdata_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU:     rdata_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit between execute and data memory
//
// Purpose: accepts one load/store, validates funct3 and alignment, drives a
//          word-addressed memory port, and holds the extended load result
//          until writeback takes it.
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests complete with rsp_err=1, no memory access
//   undefined : misaligned half/word addresses are force-aligned and proceed
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/req_ready             : upstream handshake
//   req_we, req_funct3, req_addr,
//   req_wdata, req_tag              : request fields
//   rsp_valid/rsp_ready             : downstream handshake
//   rsp_rdata, rsp_tag, rsp_err     : response fields
//   mem_req/mem_gnt                 : memory request handshake
//   mem_we, mem_addr, mem_be,
//   mem_wdata                       : memory request fields (0 when idle)
//   mem_rvalid, mem_rdata           : load return
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic             mem_we,
  output logic [XLEN-3:0]  mem_addr,
  output logic [3:0]       mem_be,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata
);

  lsu_state_e state, state_next;

  logic [XLEN-1:0]  addr_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic [XLEN-1:0]  wdata_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic [XLEN-1:0]  rdata_q;

  logic             accept;
  logic             legal;
  logic             misaligned;
  logic             req_err;
  logic [XLEN-1:0]  addr_eff;

  logic [3:0]       be_lane;
  logic [XLEN-1:0]  wdata_lane;
  logic [XLEN-1:0]  rdata_ext;

  // ---------------- request decode ----------------
  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      legal = (req_funct3 == SB) || (req_funct3 == SH) || (req_funct3 == SW);
    end else begin
      legal = (req_funct3 == LB)  || (req_funct3 == LH)  || (req_funct3 == LW) ||
              (req_funct3 == LBU) || (req_funct3 == LHU);
    end
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = !legal || misaligned;
`else
  assign req_err = !legal;
`endif

  // Force-align is harmless when trapping: a misaligned request never
  // reaches memory in that build, so the stored address is unused.
  always_comb begin
    addr_eff = req_addr;
    case (req_funct3[1:0])
      2'b01:   addr_eff = {req_addr[XLEN-1:1], 1'b0};
      2'b10:   addr_eff = {req_addr[XLEN-1:2], 2'b00};
      default: addr_eff = req_addr;
    endcase
  end

  assign accept = req_valid && req_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_err ? RESP : REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_next = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- transaction registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      addr_q   <= addr_eff;
      funct3_q <= req_funct3;
      we_q     <= req_we;
      wdata_q  <= req_wdata;
      tag_q    <= req_tag;
      err_q    <= req_err;
      rdata_q  <= '0;
    end else if ((state == WAIT) && mem_rvalid) begin
      rdata_q  <= rdata_ext;
    end
  end

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .funct3    (funct3_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .be        (be_lane),
    .wdata_lane(wdata_lane),
    .rdata_ext (rdata_ext)
  );

  // ---------------- output gating ----------------
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? addr_q[XLEN-1:2] : '0;
  assign mem_be    = mem_req ? be_lane : 4'b0000;
  assign mem_wdata = (mem_req && we_q) ? wdata_lane : '0;

  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_tag   = rsp_valid ? tag_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule
